// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_pkg                                                     |
// | Description : Shared UART types: byte width, byte type and the TX FIFO     |
// |               launcher state encoding.                                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;

    typedef logic [UART_DATA_WIDTH-1:0] uart_byte_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } uart_tx_fifo_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_sync_fifo                                               |
// | Description : Single-clock FIFO with registered full/empty/count.          |
// |               A push is accepted only when the registered full flag is 0;  |
// |               a pop is honoured only when the registered empty flag is 0.  |
// | Ports       : clk, rst        - clock, synchronous active-high reset       |
// |               i_push/i_data   - enqueue strobe and byte                    |
// |               i_pop           - dequeue strobe                             |
// |               o_head          - entry at the read pointer (combinational)  |
// |               o_full/o_empty/o_count - registered occupancy status         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_sync_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_head,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_count
);

    localparam int                c_DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_DEPTH_M1 = (DEPTH_LOG2+1)'(c_DEPTH - 1);

    logic [DATA_WIDTH-1:0] r_mem [0:c_DEPTH-1];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_full;
    logic                  r_empty;

    logic w_push;
    logic w_pop;

    assign w_push = i_push & ~r_full;
    assign w_pop  = i_pop & ~r_empty;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            // Flags are derived from the pre-update count so that all three
            // status outputs change on the same edge.
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
                r_full  <= (r_count == c_DEPTH_M1);
                r_empty <= 1'b0;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
                r_full  <= 1'b0;
                r_empty <= (r_count == (DEPTH_LOG2+1)'(1));
            end
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_tx_fifo                                                 |
// | Description : Byte queue in front of uart_transmitter. Buffers host writes |
// |               and launches them one at a time over the tx_en / tx_data /   |
// |               tx_busy handshake, with a bounded wait for tx_busy to rise.  |
// | Ports       : sys_clk, sys_rst   - clock, synchronous active-high reset    |
// |               wr_en, wr_data     - host write strobe and byte              |
// |               full, empty, count - registered occupancy status             |
// |               overflow, overflow_clear - sticky dropped-write flag / clear |
// |               tx_en, tx_data     - launch pulse and byte to transmitter    |
// |               tx_busy            - transmitter busy level                  |
// | Options     : UART_TX_FIFO_OVERFLOW_FLAG_EN - enables the overflow flag;   |
// |               when undefined overflow is tied 0 and drops are silent.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2    = 4,
    parameter int DATA_WIDTH    = UART_DATA_WIDTH,
    parameter int BUSY_WAIT_MAX = 65535
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    input  logic                  overflow_clear,
    output logic                  tx_en,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_busy
);

    // Counter sized to reach BUSY_WAIT_MAX exactly; it stops there, never wraps.
    localparam int                c_WAIT_W   = (BUSY_WAIT_MAX < 1) ? 1 : $clog2(BUSY_WAIT_MAX + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(BUSY_WAIT_MAX);

    uart_tx_fifo_state_t   r_state;
    logic                  r_tx_en;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic [c_WAIT_W-1:0]   r_wait_cnt;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_head;

    // The only pop point is the IDLE->LAUNCH transition.
    assign w_pop = (r_state == IDLE) && !w_empty;

    uart_sync_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .i_push  (wr_en),
        .i_data  (wr_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (count)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state    <= IDLE;
            r_tx_en    <= 1'b0;
            r_tx_data  <= '0;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_state   <= LAUNCH;
                        r_tx_en   <= 1'b1;
                        r_tx_data <= w_head;
                    end
                end
                LAUNCH: begin
                    r_tx_en    <= 1'b0;
                    r_wait_cnt <= '0;
                    r_state    <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // If the transmitter never acknowledges, the byte is
                    // considered sent so the queue cannot stall forever.
                    if (tx_busy) begin
                        r_state <= WAIT_DONE;
                    end else if (r_wait_cnt == c_WAIT_MAX) begin
                        r_state <= IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign tx_en   = r_tx_en;
    assign tx_data = r_tx_data;
    assign full    = w_full;
    assign empty   = w_empty;

`ifdef UART_TX_FIFO_OVERFLOW_FLAG_EN
    logic r_overflow;

    // Set has priority over clear so a drop coincident with a clear is kept.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_overflow <= 1'b0;
        end else if (wr_en && w_full) begin
            r_overflow <= 1'b1;
        end else if (overflow_clear) begin
            r_overflow <= 1'b0;
        end
    end

    assign overflow = r_overflow;
`else
    logic w_unused_overflow_clear;

    assign w_unused_overflow_clear = overflow_clear;
    assign overflow                = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_tx_fifo                                              |
// | Description : Self-checking bench for uart_tx_fifo. A queue-based model of |
// |               the byte buffer and launcher timing predicts every output    |
// |               each cycle; a reactive transmitter model drives tx_busy.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_uart_tx_fifo;

    localparam int c_DL2   = 4;
    localparam int c_DEPTH = 16;
    localparam int c_MAX   = 8;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       overflow_clear = 1'b0;
    logic       tx_busy = 1'b0;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       tx_en;
    logic [7:0] tx_data;

    always #5 sys_clk = ~sys_clk;

    uart_tx_fifo #(
        .DEPTH_LOG2    (c_DL2),
        .DATA_WIDTH    (8),
        .BUSY_WAIT_MAX (c_MAX)
    ) dut (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .wr_en          (wr_en),
        .wr_data        (wr_data),
        .full           (full),
        .empty          (empty),
        .count          (count),
        .overflow       (overflow),
        .overflow_clear (overflow_clear),
        .tx_en          (tx_en),
        .tx_data        (tx_data),
        .tx_busy        (tx_busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the queue contents plus "how long since the last launch"
    // and "has the transmitter acknowledged it" describe the launcher.
    logic [7:0] m_q[$];
    logic       m_free = 1'b1;
    int         m_age = 0;
    logic       m_saw = 1'b0;
    logic       m_tx_en = 1'b0;
    logic [7:0] m_tx_data = 8'h00;
    logic       m_ovf = 1'b0;

    // Transmitter model: busy rises bd cycles after tx_en, stays up bh cycles.
    int   busy_mode = 0;   // 0 = reactive, 1 = stuck low, 2 = stuck high
    int   bd = 3;
    int   bh = 20;
    int   tx_age = -1;
    logic busy_rand = 1'b0;

    int         cycle = 0;
    int         n_launch = 0;
    int         last_launch = 0;
    logic [7:0] log_q[$];
    int         launch_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cycle, got, exp);
        end
    endtask

    task automatic tick();
        logic full_b;
        logic pop;
        full_b = (m_q.size() == c_DEPTH);
        if (sys_rst) begin
            m_q.delete();
            m_free    = 1'b1;
            m_age     = 0;
            m_saw     = 1'b0;
            m_tx_en   = 1'b0;
            m_tx_data = 8'h00;
            m_ovf     = 1'b0;
        end else begin
            pop     = m_free && (m_q.size() > 0);
            m_tx_en = pop;
            if (!m_free) begin
                m_age++;
                // Launch edge is age 0; acknowledgement is looked for from age 2.
                if (m_age >= 2) begin
                    if (m_saw) begin
                        if (!tx_busy) m_free = 1'b1;
                    end else if (tx_busy) begin
                        m_saw = 1'b1;
                    end else if (m_age - 2 == c_MAX) begin
                        m_free = 1'b1;
                    end
                end
            end
            if (pop) begin
                m_tx_data = m_q.pop_front();
                m_free    = 1'b0;
                m_age     = 0;
                m_saw     = 1'b0;
            end
            if (wr_en && !full_b) m_q.push_back(wr_data);
`ifdef UART_TX_FIFO_OVERFLOW_FLAG_EN
            if (wr_en && full_b) m_ovf = 1'b1;
            else if (overflow_clear) m_ovf = 1'b0;
`endif
        end

        @(posedge sys_clk);
        @(negedge sys_clk);
        cycle++;

        check("tx_en", tx_en, m_tx_en);
        check("tx_data", tx_data, m_tx_data);
        check("count", count, m_q.size());
        check("full", full, m_q.size() == c_DEPTH);
        check("empty", empty, m_q.size() == 0);
        check("overflow", overflow, m_ovf);

        if (tx_en === 1'b1) begin
            n_launch++;
            last_launch = cycle;
            log_q.push_back(tx_data);
            launch_q.push_back(cycle);
            tx_age = 0;
            if (busy_rand) begin
                bd = $urandom_range(1, 12);
                bh = $urandom_range(1, 15);
            end
        end else if (tx_age >= 0) begin
            tx_age++;
        end
        case (busy_mode)
            1:       tx_busy = 1'b0;
            2:       tx_busy = 1'b1;
            default: tx_busy = (tx_age >= 0) && (tx_age + 1 >= bd) && (tx_age + 1 < bd + bh);
        endcase
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (!(m_q.size() == 0 && m_free) && k < budget) begin
            tick();
            k++;
        end
        check("drain_empty", empty, 1);
        repeat (3) tick();
    endtask

    initial begin
        int n0;
        int nxt;
        int k;

        // Reset
        sys_rst = 1'b1;
        tick();
        tick();
        sys_rst = 1'b0;
        check("rst_empty", empty, 1);
        check("rst_tx_en", tx_en, 0);

        // Single byte, driven after edge 10
        busy_mode = 0; bd = 3; bh = 20;
        while (cycle < 10) tick();
        wr_en = 1'b1; wr_data = 8'hA5;
        tick();
        wr_en = 1'b0;
        repeat (30) tick();
        check("single_launch_edge", last_launch, 12);
        check("single_n_launch", n_launch, 1);
        check("single_data", log_q[0], 8'hA5);
        check("single_tx_data_hold", tx_data, 8'hA5);

        // Burst to full with transmitter stuck busy
        log_q.delete();
        busy_mode = 2; tx_busy = 1'b1;
        for (int i = 0; i < 18; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            tick();
        end
        wr_en = 1'b0;
        check("burst_count", count, 16);
        check("burst_full", full, 1);
        check("burst_pops", log_q.size(), 1);
        busy_mode = 0; bd = 1; bh = 2;
        drain(600);
        check("burst_n_sent", log_q.size(), 17);
        for (int i = 0; i < 17 && i < log_q.size(); i++) check("burst_order", log_q[i], 8'(i));
        overflow_clear = 1'b1;
        tick();
        overflow_clear = 1'b0;

        // Ordering and wrap: 40 bytes through the reactive transmitter
        log_q.delete();
        bd = 2; bh = 3; nxt = 0; k = 0;
        while ((nxt < 40 || !(m_q.size() == 0 && m_free)) && k < 3000) begin
            wr_en = (nxt < 40) && (m_q.size() < c_DEPTH) && ($urandom_range(0, 1) == 1);
            wr_data = 8'(nxt);
            tick();
            if (wr_en) nxt++;
            k++;
        end
        wr_en = 1'b0;
        check("stream_n_sent", log_q.size(), 40);
        for (int i = 0; i < 40 && i < log_q.size(); i++) check("stream_order", log_q[i], 8'(i));

        // Simultaneous push and pop with one byte queued in IDLE
        log_q.delete();
        bd = 1; bh = 4;
        wr_en = 1'b1; wr_data = 8'h3C; tick();
        wr_data = 8'h4D; tick();
        wr_en = 1'b0;
        k = 0;
        while (!(m_free && m_q.size() == 1) && k < 100) begin tick(); k++; end
        wr_en = 1'b1; wr_data = 8'h5C;
        tick();
        wr_en = 1'b0;
        check("pushpop_count", count, 1);
        drain(200);
        check("pushpop_n_sent", log_q.size(), 3);
        if (log_q.size() == 3) begin
            check("pushpop_prev", log_q[1], 8'h4D);
            check("pushpop_next", log_q[2], 8'h5C);
        end

        // Busy timeout
        busy_mode = 1; tx_busy = 1'b0;
        launch_q.delete();
        wr_en = 1'b1; wr_data = 8'h11; tick();
        wr_data = 8'h22; tick();
        wr_en = 1'b0;
        drain(200);
        check("timeout_n_launch", launch_q.size(), 2);
        if (launch_q.size() == 2) check("timeout_gap", launch_q[1] - launch_q[0], c_MAX + 3);

        // Randomized traffic with random transmitter timing
        busy_mode = 0; busy_rand = 1'b1;
        repeat (400) begin
            wr_en = 1'($urandom_range(0, 1));
            wr_data = 8'($urandom);
            overflow_clear = ($urandom_range(0, 9) == 0);
            tick();
        end
        wr_en = 1'b0; overflow_clear = 1'b0; busy_rand = 1'b0; bd = 1; bh = 2;
        drain(1000);

        // Overflow then reset during WAIT_DONE
        busy_mode = 2; tx_busy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h80 + i);
            tick();
        end
        wr_en = 1'b0;
`ifdef UART_TX_FIFO_OVERFLOW_FLAG_EN
        check("ovf_set", overflow, 1);
`endif
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        check("mid_rst_count", count, 0);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_tx_en", tx_en, 0);
        check("mid_rst_overflow", overflow, 0);
        n0 = n_launch;
        busy_mode = 0;
        repeat (20) tick();
        check("mid_rst_no_launch", n_launch, n0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cycle);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
